ct_loader: RTL and testbench

CT_LOADER -- requirements
Module: ct_loader

---
 rtl/ct_loader.sv | 132 +++++++++++++
 tb/tb_ct_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_loader.sv
// Ciphertext loader: streams four DEGREE_N-coefficient polynomials in, reduces each
// coefficient mod q, then hands the assembled operands to the multiplier with a start pulse.
`ifndef DEGREE_N
`define DEGREE_N 4
`endif
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif

module ct_loader #(
    parameter int unsigned DEGREE_N  = `DEGREE_N,
    parameter int unsigned BIT_WIDTH = `BIT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BIT_WIDTH-1:0]          q,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIT_WIDTH-1:0]          in_coeff,
    input  logic                          in_last,
    output logic [DEGREE_N*BIT_WIDTH-1:0] ct00,
    output logic [DEGREE_N*BIT_WIDTH-1:0] ct01,
    output logic [DEGREE_N*BIT_WIDTH-1:0] ct10,
    output logic [DEGREE_N*BIT_WIDTH-1:0] ct11,
    output logic                          start_o,
    input  logic                          done_i,
    output logic                          frame_err,
    output logic                          range_err
);

    localparam int unsigned IW = (DEGREE_N > 1) ? $clog2(DEGREE_N) : 1;
    localparam int unsigned XW = BIT_WIDTH + 1;
    localparam int unsigned PW = DEGREE_N * BIT_WIDTH;
    localparam logic [IW-1:0] LAST_COEFF = IW'(DEGREE_N - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       poly_idx;
    logic [IW-1:0]    coeff_idx;
    logic [PW-1:0]    poly [4];

    logic             accept;
    logic             last_slot;
    logic [XW-1:0]    coeff_x;
    logic [XW-1:0]    q_x;
    logic [XW-1:0]    q2_x;
    logic [BIT_WIDTH-1:0] red_c;
    logic             over_c;

    assign in_ready  = (state == LOAD) && !rst;
    assign accept    = in_valid && in_ready;
    assign last_slot = (poly_idx == 2'd3) && (coeff_idx == LAST_COEFF);

    assign ct00 = poly[0];
    assign ct01 = poly[1];
    assign ct10 = poly[2];
    assign ct11 = poly[3];

    // One conditional subtraction; the extra bit keeps 2q from overflowing.
    always_comb begin
        coeff_x = XW'(in_coeff);
        q_x     = XW'(q);
        q2_x    = {q, 1'b0};
        red_c   = in_coeff;
        over_c  = 1'b0;
        if (coeff_x >= q2_x) begin
            red_c  = '0;
            over_c = 1'b1;
        end else if (coeff_x >= q_x) begin
            red_c = BIT_WIDTH'(coeff_x - q_x);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            poly_idx  <= '0;
            coeff_idx <= '0;
            start_o   <= 1'b0;
            frame_err <= 1'b0;
            range_err <= 1'b0;
            for (int p = 0; p < 4; p++) begin
                poly[p] <= '0;
            end
        end else begin
            start_o <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        poly[poly_idx][coeff_idx*BIT_WIDTH +: BIT_WIDTH] <= red_c;
                        if (over_c) begin
                            range_err <= 1'b1;
                        end
                        if (last_slot && in_last) begin
                            state     <= ISSUE;
                            start_o   <= 1'b1;
                            poly_idx  <= '0;
                            coeff_idx <= '0;
                        end else if (last_slot || in_last) begin
                            // Early or missing last: drop the frame and resync on the next beat.
                            frame_err <= 1'b1;
                            poly_idx  <= '0;
                            coeff_idx <= '0;
                        end else if (coeff_idx == LAST_COEFF) begin
                            coeff_idx <= '0;
                            poly_idx  <= poly_idx + 2'd1;
                        end else begin
                            coeff_idx <= coeff_idx + IW'(1);
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (done_i) begin
                        state <= LOAD;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ct_loader.sv
// Randomized self-checking bench for ct_loader: frames are modelled as lists of beats and the
// expected polynomials are computed from the reduction rule directly.
module tb_ct_loader;

    localparam int unsigned N  = 4;
    localparam int unsigned BW = 16;
    localparam int unsigned NB = 4 * N;
    localparam int unsigned PW = N * BW;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] q;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_coeff;
    logic          in_last;
    logic [PW-1:0] ct00, ct01, ct10, ct11;
    logic          start_o;
    logic          done_i;
    logic          frame_err;
    logic          range_err;

    int errors     = 0;
    int checks     = 0;
    int start_cnt  = 0;
    int exp_starts = 0;
    bit exp_range  = 1'b0;
    bit exp_frame  = 1'b0;
    logic [BW-1:0] fb [NB];

    ct_loader #(.DEGREE_N(N), .BIT_WIDTH(BW)) dut (
        .clk(clk), .rst(rst), .q(q),
        .in_valid(in_valid), .in_ready(in_ready), .in_coeff(in_coeff), .in_last(in_last),
        .ct00(ct00), .ct01(ct01), .ct10(ct10), .ct11(ct11),
        .start_o(start_o), .done_i(done_i),
        .frame_err(frame_err), .range_err(range_err)
    );

    always #5 clk = ~clk;

    // Count start pulses shortly after each edge, clear of the checking negedges.
    always @(posedge clk) begin
        #2;
        if (start_o === 1'b1) start_cnt++;
    end

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] red(input logic [BW-1:0] c);
        int ci = int'(c);
        int qi = int'(q);
        if (ci < qi) return c;
        else if (ci < 2 * qi) return BW'(ci - qi);
        else return '0;
    endfunction

    function automatic logic [PW-1:0] exp_poly(input int p);
        logic [PW-1:0] v = '0;
        for (int k = 0; k < N; k++) v[k*BW +: BW] = red(fb[p*N + k]);
        return v;
    endfunction

    task automatic fill_const();
        for (int i = 0; i < NB; i++) fb[i] = BW'(i / N + 1);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NB; i++) begin
            if ($urandom_range(0, 7) == 0) fb[i] = BW'($urandom_range(2 * int'(q), 65535));
            else fb[i] = BW'($urandom_range(0, 2 * int'(q) - 1));
        end
    endtask

    task automatic send_beat(input logic [BW-1:0] c, input bit last, input int gap);
        int n = 0;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_coeff = c;
        in_last  = last;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", PW'(0), PW'(1));
        @(posedge clk);
    endtask

    // gapmode: 0 back-to-back, 1 strict alternation, 2 random idle cycles.
    task automatic send_frame(input int nbeats, input int last_at, input int gapmode);
        int gap;
        for (int i = 0; i < nbeats; i++) begin
            gap = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : int'($urandom_range(0, 2));
            send_beat(fb[i], (i == last_at), gap);
            if (int'(fb[i]) >= 2 * int'(q)) exp_range = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!(nbeats == NB && last_at == NB - 1)) exp_frame = 1'b1;
        else exp_starts++;
    endtask

    // Called on the negedge right after the final beat of a good frame.
    task automatic check_issued(input string tag);
        chk({tag, "_start"}, PW'(start_o), PW'(1));
        chk({tag, "_ready_issue"}, PW'(in_ready), PW'(0));
        chk({tag, "_ct00"}, ct00, exp_poly(0));
        chk({tag, "_ct01"}, ct01, exp_poly(1));
        chk({tag, "_ct10"}, ct10, exp_poly(2));
        chk({tag, "_ct11"}, ct11, exp_poly(3));
        chk({tag, "_range_err"}, PW'(range_err), PW'(exp_range));
        chk({tag, "_frame_err"}, PW'(frame_err), PW'(exp_frame));
        @(negedge clk);
        chk({tag, "_start_once"}, PW'(start_o), PW'(0));
        chk({tag, "_ready_wait"}, PW'(in_ready), PW'(0));
    endtask

    task automatic release_wait(input string tag);
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_coeff = BW'($urandom);
        repeat (3) @(negedge clk);
        chk({tag, "_wait_hold"}, PW'(in_ready), PW'(0));
        chk({tag, "_ct_stable"}, ct11, exp_poly(3));
        in_valid = 1'b0;
        in_last  = 1'b0;
        done_i   = 1'b1;
        @(negedge clk);
        done_i   = 1'b0;
        chk({tag, "_ready_after_done"}, PW'(in_ready), PW'(1));
        chk({tag, "_start_count"}, PW'(start_cnt), PW'(exp_starts));
    endtask

    task automatic check_reject(input string tag);
        chk({tag, "_no_start"}, PW'(start_o), PW'(0));
        chk({tag, "_frame_err"}, PW'(frame_err), PW'(1));
        chk({tag, "_ready"}, PW'(in_ready), PW'(1));
        repeat (2) @(negedge clk);
        chk({tag, "_start_count"}, PW'(start_cnt), PW'(exp_starts));
    endtask

    initial begin
        rst = 1'b1; q = BW'(9); in_valid = 1'b0; in_coeff = '0; in_last = 1'b0; done_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", PW'(in_ready), PW'(0));
        chk("rst_start", PW'(start_o), PW'(0));
        chk("rst_ct00", ct00, '0);
        chk("rst_ct11", ct11, '0);
        chk("rst_errs", PW'({frame_err, range_err}), PW'(0));
        rst = 1'b0;
        #1;
        chk("ready_after_rst", PW'(in_ready), PW'(1));

        // Basic frame, with a stray done_i in LOAD first.
        @(negedge clk); done_i = 1'b1;
        @(negedge clk); done_i = 1'b0;
        chk("done_in_load", PW'(in_ready), PW'(1));
        fill_const();
        send_frame(NB, NB - 1, 0);
        check_issued("basic");
        release_wait("basic");

        // Reduction corner values in ct00.
        fill_rand();
        fb[0] = BW'(8); fb[1] = BW'(9); fb[2] = BW'(10); fb[3] = BW'(20);
        send_frame(NB, NB - 1, 2);
        chk("reduce_ct00", ct00, {BW'(0), BW'(1), BW'(0), BW'(8)});
        check_issued("reduce");
        release_wait("reduce");

        // Early last on beat 5, then a clean frame.
        fill_rand();
        send_frame(5, 4, 0);
        check_reject("early_last");
        fill_rand();
        send_frame(NB, NB - 1, 0);
        check_issued("after_early");
        release_wait("after_early");

        // Missing last on beat 16, then a clean frame.
        fill_rand();
        send_frame(NB, -1, 2);
        check_reject("missing_last");
        fill_rand();
        send_frame(NB, NB - 1, 2);
        check_issued("after_missing");
        release_wait("after_missing");

        // Alternating backpressure.
        fill_const();
        send_frame(NB, NB - 1, 1);
        check_issued("backpressure");
        release_wait("backpressure");

        // Reset while waiting on the multiplier; a late done_i must be ignored.
        fill_rand();
        send_frame(NB, NB - 1, 0);
        check_issued("pre_reset");
        rst = 1'b1;
        @(negedge clk);
        chk("wrst_ct00", ct00, '0);
        chk("wrst_ct10", ct10, '0);
        chk("wrst_start", PW'(start_o), PW'(0));
        chk("wrst_errs", PW'({frame_err, range_err}), PW'(0));
        chk("wrst_ready", PW'(in_ready), PW'(0));
        rst = 1'b0;
        exp_range = 1'b0;
        exp_frame = 1'b0;
        @(negedge clk); done_i = 1'b1;
        @(negedge clk); done_i = 1'b0;
        chk("late_done_ready", PW'(in_ready), PW'(1));
        chk("late_done_starts", PW'(start_cnt), PW'(exp_starts));
        fill_rand();
        send_frame(NB, NB - 1, 2);
        check_issued("post_reset");
        release_wait("post_reset");

        // Random moduli and coefficients.
        for (int f = 0; f < 6; f++) begin
            q = BW'($urandom_range(1, 20000));
            fill_rand();
            send_frame(NB, NB - 1, 2);
            check_issued("rand");
            release_wait("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
